// File: rtl/cell_fetch_pkg.sv
// Shared constants for the ROI cell fetcher: FSM state encoding and default frame geometry.
package cell_fetch_pkg;

    localparam int DEF_CELL_WIDTH = 768;
    localparam int DEF_CELL_COLS  = 40;
    localparam int DEF_CELL_ROWS  = 30;

    localparam int STALL_CNT_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/roi_cell_fetch_if.sv
// Valid/ready cell stream; data carries {eol, last, cell} inside the fetcher.
interface roi_cell_fetch_if #(
    parameter int DATA_W = 770
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/skid_buffer.sv
// Fully registered two-entry skid buffer: output and input ready both come straight from flops.
module skid_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    roi_cell_fetch_if.slave   s,
    roi_cell_fetch_if.master  m
);

    logic              out_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] skid_data;

    assign s.ready = ~skid_valid;
    assign m.valid = out_valid;
    assign m.data  = out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else if (m.ready || !out_valid) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= s.valid;
                if (s.valid) begin
                    out_data <= s.data;
                end
            end
        end else if (s.valid && !skid_valid) begin
            // output stalled: park the accepted beat so upstream sees ready drop one cycle late
            skid_data  <= s.data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/roi_cell_fetch.sv
// Streams a rectangular ROI of cells from the cell cache to the HOG stage in raster order.
// Optional ROI_CELL_FETCH_STALL_CNT_EN enables the backpressure cycle counter on stall_cnt_o.
module roi_cell_fetch
    import cell_fetch_pkg::*;
#(
    parameter int CELL_WIDTH  = DEF_CELL_WIDTH,
    parameter int CELL_COLS   = DEF_CELL_COLS,
    parameter int CELL_ROWS   = DEF_CELL_ROWS,
    localparam int CELL_NUM    = CELL_COLS * CELL_ROWS,
    localparam int CELL_ADDR_W = $clog2(CELL_NUM),
    localparam int COL_W       = $clog2(CELL_COLS + 1),
    localparam int ROW_W       = $clog2(CELL_ROWS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cell_fetch_start_i,
    input  logic                   cell_fetch_abort_i,
    input  logic [COL_W-1:0]       roi_col_start_i,
    input  logic [ROW_W-1:0]       roi_row_start_i,
    input  logic [COL_W-1:0]       roi_cols_i,
    input  logic [ROW_W-1:0]       roi_rows_i,
    input  logic [CELL_WIDTH-1:0]  bwd_cell_data_i,
    input  logic                   fwd_cell_ready_i,
    output logic [CELL_ADDR_W-1:0] bwd_cell_addr_o,
    output logic [CELL_WIDTH-1:0]  fwd_cell_data_o,
    output logic                   fwd_cell_valid_o,
    output logic                   fwd_cell_eol_o,
    output logic                   fwd_cell_last_o,
    output logic                   cell_fetch_busy_o,
    output logic                   cell_fetch_done_o,
    output logic                   cfg_err_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam logic [CELL_ADDR_W-1:0] ROW_STEP = CELL_ADDR_W'(CELL_COLS);

    logic [1:0]             state;
    logic [COL_W-1:0]       col_start_q;
    logic [COL_W-1:0]       cols_q;
    logic [ROW_W-1:0]       rows_q;
    logic [COL_W-1:0]       col_cnt;
    logic [ROW_W-1:0]       row_cnt;
    logic [CELL_ADDR_W-1:0] addr_q;
    logic [CELL_ADDR_W-1:0] row_base;
    logic [CELL_ADDR_W-1:0] start_base;
    logic                   cfg_err_q;
    logic                   roi_ok;
    logic                   start_ok;
    logic                   beat_acc;
    logic                   eol_beat;
    logic                   last_beat;

    roi_cell_fetch_if #(.DATA_W(CELL_WIDTH + 2)) buf_in ();
    roi_cell_fetch_if #(.DATA_W(CELL_WIDTH + 2)) buf_out ();

    skid_buffer #(.DATA_W(CELL_WIDTH + 2)) u_skid (
        .clk (clk),
        .rst (rst),
        .s   (buf_in),
        .m   (buf_out)
    );

    always_comb begin
        roi_ok = (roi_cols_i != '0) && (roi_rows_i != '0)
              && (int'(roi_col_start_i) + int'(roi_cols_i) <= CELL_COLS)
              && (int'(roi_row_start_i) + int'(roi_rows_i) <= CELL_ROWS);
    end

    // the only multiply: row base of the first ROI row, later rows step by CELL_COLS
    assign start_base = CELL_ADDR_W'(int'(roi_row_start_i) * CELL_COLS);
    assign start_ok   = (state == ST_IDLE) && cell_fetch_start_i && roi_ok;

    assign eol_beat  = (col_cnt == cols_q - COL_W'(1));
    assign last_beat = eol_beat && (row_cnt == rows_q - ROW_W'(1));
    assign beat_acc  = (state == ST_FETCH) && buf_in.ready;

    assign buf_in.valid  = (state == ST_FETCH);
    assign buf_in.data   = {eol_beat, last_beat, bwd_cell_data_i};
    assign buf_out.ready = fwd_cell_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            col_start_q <= '0;
            cols_q      <= '0;
            rows_q      <= '0;
            col_cnt     <= '0;
            row_cnt     <= '0;
            addr_q      <= '0;
            row_base    <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cell_fetch_start_i) begin
                        if (roi_ok) begin
                            col_start_q <= roi_col_start_i;
                            cols_q      <= roi_cols_i;
                            rows_q      <= roi_rows_i;
                            col_cnt     <= '0;
                            row_cnt     <= '0;
                            row_base    <= start_base;
                            addr_q      <= start_base + CELL_ADDR_W'(roi_col_start_i);
                            state       <= ST_FETCH;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (beat_acc) begin
                        if (eol_beat) begin
                            col_cnt  <= '0;
                            row_cnt  <= row_cnt + ROW_W'(1);
                            row_base <= row_base + ROW_STEP;
                            addr_q   <= row_base + ROW_STEP + CELL_ADDR_W'(col_start_q);
                        end else begin
                            col_cnt <= col_cnt + COL_W'(1);
                            addr_q  <= addr_q + CELL_ADDR_W'(1);
                        end
                    end
                    // a final beat accepted alongside abort still carries last, so done follows
                    if (cell_fetch_abort_i || (beat_acc && last_beat)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!buf_out.valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ROI_CELL_FETCH_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if ((state != ST_IDLE) && buf_out.valid && !fwd_cell_ready_i
                     && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

    assign bwd_cell_addr_o   = addr_q;
    assign fwd_cell_data_o   = buf_out.data[CELL_WIDTH-1:0];
    assign fwd_cell_last_o   = buf_out.data[CELL_WIDTH];
    assign fwd_cell_eol_o    = buf_out.data[CELL_WIDTH+1];
    assign fwd_cell_valid_o  = buf_out.valid;
    assign cell_fetch_busy_o = (state != ST_IDLE);
    assign cell_fetch_done_o = buf_out.valid && fwd_cell_ready_i && fwd_cell_last_o;
    assign cfg_err_o         = cfg_err_q;

endmodule

// File: tb/tb_roi_cell_fetch.sv
// Directed + randomized bench for roi_cell_fetch against a raster-order ROI reference model.
module tb_roi_cell_fetch;

    localparam int W  = 768;
    localparam int NC = 40;
    localparam int NR = 30;
    localparam int N  = NC * NR;
    localparam int AW = 11;
    localparam int CW = 6;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] cs_i;
    logic [CW-1:0] nc_i;
    logic [RW-1:0] rs_i;
    logic [RW-1:0] nr_i;
    logic [W-1:0]  bwd_data;
    logic [AW-1:0] bwd_addr;
    logic          eol;
    logic          last;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [15:0]   stall;

    roi_cell_fetch_if #(.DATA_W(W)) fwd ();

    always #5 clk = ~clk;

    logic [W-1:0] mem [N];
    assign bwd_data = (int'(bwd_addr) < N) ? mem[bwd_addr] : '0;

    roi_cell_fetch dut (
        .clk                (clk),
        .rst                (rst),
        .cell_fetch_start_i (start),
        .cell_fetch_abort_i (abort),
        .roi_col_start_i    (cs_i),
        .roi_row_start_i    (rs_i),
        .roi_cols_i         (nc_i),
        .roi_rows_i         (nr_i),
        .bwd_cell_data_i    (bwd_data),
        .fwd_cell_ready_i   (fwd.ready),
        .bwd_cell_addr_o    (bwd_addr),
        .fwd_cell_data_o    (fwd.data),
        .fwd_cell_valid_o   (fwd.valid),
        .fwd_cell_eol_o     (eol),
        .fwd_cell_last_o    (last),
        .cell_fetch_busy_o  (busy),
        .cell_fetch_done_o  (done),
        .cfg_err_o          (cfg_err),
        .stall_cnt_o        (stall)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int addr;
        bit eol;
        bit last;
    } beat_t;

    beat_t exp_q[$];

    // reference: every cell of the rectangle, row by row, left to right
    function automatic void build_model(input int cs, input int rs, input int c, input int r);
        exp_q.delete();
        for (int y = 0; y < r; y++) begin
            for (int x = 0; x < c; x++) begin
                exp_q.push_back('{(rs + y) * NC + cs + x, x == c - 1, (x == c - 1) && (y == r - 1)});
            end
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   fwd.valid, 0);
        check({tag, "_eol"},     eol,       0);
        check({tag, "_last"},    last,      0);
        check({tag, "_busy"},    busy,      0);
        check({tag, "_done"},    done,      0);
        check({tag, "_cfg_err"}, cfg_err,   0);
        check({tag, "_stall"},   stall,     0);
        check({tag, "_addr"},    bwd_addr,  0);
        check({tag, "_data"},    fwd.data,  0);
    endtask

    // rmode: 0 ready high, 1 ready alternating 1/0 from first valid cycle, 2 random
    task automatic run_roi(input int cs, input int rs, input int c, input int r,
                           input int rmode, input int abort_after, input bit poke_start,
                           input int exp_stall, output int beats, output int dones);
        int n = 0;
        int errs = 0;
        bit stalled = 0;
        bit abort_pend = 0;
        logic [W-1:0] held = '0;
        dones = 0;
        build_model(cs, rs, c, r);
        @(negedge clk);
        cs_i = CW'(cs); rs_i = RW'(rs); nc_i = CW'(c); nr_i = RW'(r);
        start = 1'b1;
        fwd.ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("busy_after_start", busy, 1);
        check("first_addr", bwd_addr, exp_q[0].addr);
        check("no_valid_cycle0", fwd.valid, 0);
        for (int cyc = 1; cyc < 6000; cyc++) begin
            @(negedge clk);
            case (rmode)
                0:       fwd.ready = 1'b1;
                1:       fwd.ready = (cyc % 2) == 1;
                default: fwd.ready = 1'($urandom_range(0, 1));
            endcase
            abort = abort_pend;
            abort_pend = 1'b0;
            if (poke_start && cyc == 5) begin
                start = 1'b1; cs_i = CW'(39); nc_i = CW'(5);
            end else begin
                start = 1'b0;
            end
            #1;
            if (cyc == 1) check("first_valid_latency", fwd.valid, 1);
            if (fwd.valid && stalled) check("hold_data", fwd.data, held);
            stalled = 1'b0;
            if (fwd.valid) begin
                if (fwd.ready) begin
                    if (n < exp_q.size()) begin
                        check("beat_data", fwd.data, mem[exp_q[n].addr]);
                        check("beat_eol", eol, exp_q[n].eol);
                        check("beat_last", last, exp_q[n].last);
                    end else begin
                        check("beat_overrun", n, exp_q.size() - 1);
                    end
                    n++;
                    if (abort_after > 0 && n == abort_after) abort_pend = 1'b1;
                end else begin
                    held = fwd.data;
                    stalled = 1'b1;
                end
            end
            if (done) begin
                dones++;
                if (exp_stall >= 0) check("stall_at_done", stall, exp_stall);
            end
            if (cfg_err) errs++;
            if (!busy) break;
        end
        start = 1'b0;
        abort = 1'b0;
        check("busy_low_at_end", busy, 0);
        check("no_cfg_err_while_busy", errs, 0);
        beats = n;
    endtask

    task automatic cfg_err_case(input int cs, input int rs, input int c, input int r);
        @(negedge clk);
        cs_i = CW'(cs); rs_i = RW'(rs); nc_i = CW'(c); nr_i = RW'(r);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        @(negedge clk);
        #1;
        check("cfg_err_one_cycle", cfg_err, 0);
        check("cfg_err_no_beat", fwd.valid, 0);
        check("cfg_err_still_idle", busy, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b;
        int d;
        int stall_exp;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < W / 32; k++) mem[i][k*32 +: 32] = $urandom();
        end
        rst = 1'b1; start = 1'b0; abort = 1'b0; fwd.ready = 1'b0;
        cs_i = '0; rs_i = '0; nc_i = '0; nr_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        run_roi(0, 0, 40, 30, 0, 0, 0, -1, b, d);
        check("full_beats", b, 1200);
        check("full_done", d, 1);

        run_roi(5, 2, 3, 2, 0, 0, 0, -1, b, d);
        check("roi523_beats", b, 6);
        check("roi523_done", d, 1);

        run_roi(39, 29, 1, 1, 0, 0, 0, -1, b, d);
        check("roi1x1_beats", b, 1);
        check("roi1x1_done", d, 1);

        cfg_err_case(38, 0, 3, 1);
        cfg_err_case(0, 0, 0, 4);
        cfg_err_case(2, 3, 5, 0);
        cfg_err_case(0, 25, 4, 6);

`ifdef ROI_CELL_FETCH_STALL_CNT_EN
        stall_exp = 3;
`else
        stall_exp = 0;
`endif
        run_roi(0, 0, 4, 1, 1, 0, 0, stall_exp, b, d);
        check("toggle_beats", b, 4);
        check("toggle_done", d, 1);

        run_roi(0, 0, 40, 30, 0, 10, 0, -1, b, d);
        check("abort_beats_le12", b <= 12, 1);
        check("abort_beats_ge10", b >= 10, 1);
        check("abort_no_done", d, 0);

        run_roi(0, 0, 40, 30, 2, 0, 1, -1, b, d);
        check("post_abort_beats", b, 1200);
        check("post_abort_done", d, 1);

        for (int t = 0; t < 6; t++) begin
            int c = $urandom_range(1, NC);
            int r = $urandom_range(1, 8);
            int cs = $urandom_range(0, NC - c);
            int rs = $urandom_range(0, NR - r);
            run_roi(cs, rs, c, r, 2, 0, t == 2, -1, b, d);
            check("rand_beats", b, c * r);
            check("rand_done", d, 1);
        end

        @(negedge clk);
        cs_i = '0; rs_i = '0; nc_i = CW'(40); nr_i = RW'(30);
        start = 1'b1; fwd.ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("midreset");
        rst = 1'b0;
        run_roi(0, 0, 40, 30, 2, 0, 0, -1, b, d);
        check("after_reset_beats", b, 1200);
        check("after_reset_done", d, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/roi_cell_fetch.md
ROI_CELL_FETCH -- requirements
Module: roi_cell_fetch

Interface
REQ-001 Parameter CELL_WIDTH, default 768, bits per cell.
REQ-002 Parameter CELL_COLS, default 40, cells per frame row; CELL_ROWS, default 30, cell rows per frame.
REQ-003 Derived: CELL_NUM=CELL_COLS*CELL_ROWS; CELL_ADDR_W=$clog2(CELL_NUM); COL_W=$clog2(CELL_COLS+1); ROW_W=$clog2(CELL_ROWS+1).
REQ-004 Ports, in order (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cell_fetch_start_i  in  1  start pulse; ROI inputs sampled on it.
- cell_fetch_abort_i  in  1  stop issuing reads.
- roi_col_start_i  in  COL_W  first ROI column.
- roi_row_start_i  in  ROW_W  first ROI row.
- roi_cols_i  in  COL_W  ROI width in cells.
- roi_rows_i  in  ROW_W  ROI height in cells.
- bwd_cell_data_i  in  CELL_WIDTH  cache read data, combinational from address.
- fwd_cell_ready_i  in  1  HOG ready.
- bwd_cell_addr_o  out  CELL_ADDR_W  cache read address.
- fwd_cell_data_o  out  CELL_WIDTH  cell to HOG.
- fwd_cell_valid_o  out  1  cell valid.
- fwd_cell_eol_o  out  1  beat is last of an ROI row.
- fwd_cell_last_o  out  1  beat is last of the ROI.
- cell_fetch_busy_o  out  1  operation in progress.
- cell_fetch_done_o  out  1  one-cycle completion pulse.
- cfg_err_o  out  1  one-cycle pulse, start rejected.
- stall_cnt_o  out  16  backpressure cycle count.

Function
REQ-005 States IDLE, FETCH, DRAIN; busy = state != IDLE.
REQ-006 IDLE + start: ROI valid iff cols>=1, rows>=1, col_start+cols<=CELL_COLS, row_start+rows<=CELL_ROWS; valid -> FETCH next cycle, ROI latched; invalid -> stay IDLE, cfg_err_o pulses next cycle.
REQ-007 Start while busy ignored; no err pulse.
REQ-008 Entering FETCH: address = row_start*CELL_COLS+col_start; row base register advances by CELL_COLS per row (no runtime multiplier beyond start).
REQ-009 In FETCH, buffer input valid=1; on buffer acceptance address advances raster-order within ROI: column+1, at ROI row end jump to next row base + col_start.
REQ-010 eol set on accepted beat at last ROI column; last set on final ROI beat; both travel with data through the buffer.
REQ-011 Final beat accepted -> DRAIN; DRAIN exits to IDLE when buffer empty (fwd valid low); done_o pulses in the cycle the last beat handshakes on fwd side.
REQ-012 Abort in FETCH -> DRAIN next cycle, no further beats enter; already-buffered beats still delivered; done_o not pulsed; abort ignored in IDLE/DRAIN.
REQ-013 Abort and final-beat acceptance same cycle: final beat kept, treated as completion (done_o pulses).
REQ-014 Throughput one cell/cycle with ready held high; first beat valid 2 cycles after start.
REQ-015 1x1 ROI: single beat with eol=1, last=1.

Reset
REQ-016 rst: state IDLE, address 0, buffer empty; all outputs 0 (fwd_valid, eol, last, busy, done, cfg_err, stall_cnt).
REQ-017 rst mid-frame aborts immediately; no done pulse; buffered beats discarded.

Configuration
REQ-018 Macro ROI_CELL_FETCH_STALL_CNT_EN defined: stall_cnt_o counts cycles with fwd_valid=1 and ready=0 while busy, cleared on accepted start, saturates at 0xFFFF.
REQ-019 Macro undefined: port still present, tied 0, no counter logic.

Structure
REQ-020 Package cell_fetch_pkg holds state encoding and default geometry constants (40, 30, 768).
REQ-021 One sub-module: existing skid_buffer, full-registered type, data width CELL_WIDTH+2 (eol, last).

Verification
REQ-022 Full frame 0,0,40,30, ready=1 -> 1200 beats, addresses 0..1199, eol every 40th, last at 1199, done once.
REQ-023 ROI 5,2,3,2 -> addresses 85,86,87,125,126,127; eol on 87,127; last on 127.
REQ-024 ROI 38,0,3,1 -> cfg_err_o pulse, busy stays 0, no beats.
REQ-025 Ready toggled 1-0 with macro on, ROI 0,0,4,1 -> 4 beats in order, data unchanged during stalls, stall_cnt_o=3 at done.
REQ-026 Abort after 10th accepted beat, full frame -> at most 12 beats delivered, no last, no done, busy low after drain; next start runs full frame cleanly.
REQ-027 rst asserted mid-frame -> all outputs 0 next cycle; subsequent start produces address 0 first.
